// File: rtl/picomem_dbg_master_if.sv
// Byte-stream and PicoMem bus bundle for picomem_dbg_master.
// The master modport is the debug master's view; the slave modport is the view of its environment.
interface picomem_dbg_master_if;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        mem_m_valid;
    logic        mem_m_ready;
    logic [31:0] mem_m_addr;
    logic [31:0] mem_m_wdata;
    logic [3:0]  mem_m_wstrb;
    logic [31:0] mem_m_rdata;

    modport master (
        input  rx_data, rx_valid, tx_ready, mem_m_ready, mem_m_rdata,
        output rx_ready, tx_data, tx_valid, mem_m_valid, mem_m_addr, mem_m_wdata, mem_m_wstrb
    );

    modport slave (
        output rx_data, rx_valid, tx_ready, mem_m_ready, mem_m_rdata,
        input  rx_ready, tx_data, tx_valid, mem_m_valid, mem_m_addr, mem_m_wdata, mem_m_wstrb
    );
endinterface

// File: rtl/picomem_dbg_master.sv
// Byte-packet driven PicoMem master: decodes read/write packets, runs one bus access, streams the reply.
// Optional bus timeout enabled by defining PICOMEM_DBG_TIMEOUT_EN.
module picomem_dbg_master #(
    parameter logic [7:0] RESP_ACK = 8'hAA,
    parameter logic [7:0] RESP_ERR = 8'hEE
`ifdef PICOMEM_DBG_TIMEOUT_EN
    , parameter int TIMEOUT_CYCLES = 1024
`endif
) (
    input  logic                 clk,
    input  logic                 resetn,
    picomem_dbg_master_if.master bus,
    output logic                 busy
);
    typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_BUS, S_RESP} state_t;

    state_t      state_reg, state_next;
    logic        rx_ready_reg, rx_ready_next;
    logic        tx_valid_reg;
    logic [31:0] resp_reg;
    logic [1:0]  resp_last_reg;
    logic [1:0]  cnt_reg;
    logic        is_write_reg;
    logic        mem_valid_reg;
    logic [29:0] addr_reg;
    logic [31:0] wdata_reg;
    logic [3:0]  wstrb_reg;
    logic        rx_fire, tx_fire, bus_done, bus_tmo, op_ok, last_byte;

    assign rx_fire   = bus.rx_valid && rx_ready_reg;
    assign tx_fire   = tx_valid_reg && bus.tx_ready;
    assign bus_done  = mem_valid_reg && bus.mem_m_ready;
    assign op_ok     = (bus.rx_data == 8'h01) || (bus.rx_data == 8'h02);
    assign last_byte = (cnt_reg == 2'd3);

`ifdef PICOMEM_DBG_TIMEOUT_EN
    localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);
    logic [31:0] tmo_cnt_reg;

    // Counts BUS cycles from zero; a ready in the final allowed cycle still wins.
    always_ff @(posedge clk) begin
        if (!resetn || state_reg != S_BUS)
            tmo_cnt_reg <= '0;
        else
            tmo_cnt_reg <= tmo_cnt_reg + 32'd1;
    end
    assign bus_tmo = (state_reg == S_BUS) && !bus.mem_m_ready && (tmo_cnt_reg == TMO_LAST);
`else
    assign bus_tmo = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!resetn)
            state_reg <= S_IDLE;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: if (rx_fire) state_next = op_ok ? S_ADDR : S_RESP;
            S_ADDR: if (rx_fire && last_byte) state_next = is_write_reg ? S_DATA : S_BUS;
            S_DATA: if (rx_fire && last_byte) state_next = S_BUS;
            S_BUS:  if (bus_done || bus_tmo) state_next = S_RESP;
            S_RESP: if (tx_fire && cnt_reg == resp_last_reg) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy          = (state_reg != S_IDLE);
        rx_ready_next = (state_next == S_IDLE) || (state_next == S_ADDR) || (state_next == S_DATA);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            rx_ready_reg  <= 1'b0;
            tx_valid_reg  <= 1'b0;
            resp_reg      <= '0;
            resp_last_reg <= '0;
            cnt_reg       <= '0;
            is_write_reg  <= 1'b0;
            mem_valid_reg <= 1'b0;
            addr_reg      <= '0;
            wdata_reg     <= '0;
            wstrb_reg     <= '0;
        end else begin
            rx_ready_reg <= rx_ready_next;
            case (state_reg)
                S_IDLE: begin
                    cnt_reg <= '0;
                    if (rx_fire) begin
                        is_write_reg <= (bus.rx_data == 8'h02);
                        if (!op_ok) begin
                            resp_reg      <= {24'h0, RESP_ERR};
                            resp_last_reg <= 2'd0;
                            tx_valid_reg  <= 1'b1;
                        end
                    end
                end
                S_ADDR: if (rx_fire) begin
                    // Only word-address bits are kept; packet bits [1:0] fall off the bottom.
                    addr_reg <= {bus.rx_data, addr_reg[29:8]};
                    cnt_reg  <= cnt_reg + 2'd1;
                    if (last_byte && !is_write_reg) begin
                        mem_valid_reg <= 1'b1;
                        wstrb_reg     <= 4'h0;
                    end
                end
                S_DATA: if (rx_fire) begin
                    wdata_reg <= {bus.rx_data, wdata_reg[31:8]};
                    cnt_reg   <= cnt_reg + 2'd1;
                    if (last_byte) begin
                        mem_valid_reg <= 1'b1;
                        wstrb_reg     <= 4'hF;
                    end
                end
                S_BUS: begin
                    if (bus_done) begin
                        mem_valid_reg <= 1'b0;
                        tx_valid_reg  <= 1'b1;
                        resp_reg      <= is_write_reg ? {24'h0, RESP_ACK} : bus.mem_m_rdata;
                        resp_last_reg <= is_write_reg ? 2'd0 : 2'd3;
                    end else if (bus_tmo) begin
                        mem_valid_reg <= 1'b0;
                        tx_valid_reg  <= 1'b1;
                        resp_reg      <= {24'h0, RESP_ERR};
                        resp_last_reg <= 2'd0;
                    end
                end
                S_RESP: if (tx_fire) begin
                    if (cnt_reg == resp_last_reg) begin
                        tx_valid_reg <= 1'b0;
                        cnt_reg      <= '0;
                    end else begin
                        cnt_reg  <= cnt_reg + 2'd1;
                        resp_reg <= {8'h00, resp_reg[31:8]};
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.rx_ready    = rx_ready_reg;
    assign bus.tx_valid    = tx_valid_reg;
    assign bus.tx_data     = resp_reg[7:0];
    assign bus.mem_m_valid = mem_valid_reg;
    assign bus.mem_m_addr  = {addr_reg, 2'b00};
    assign bus.mem_m_wdata = wdata_reg;
    assign bus.mem_m_wstrb = wstrb_reg;
endmodule

// File: tb/tb_picomem_dbg_master.sv
// Self-checking bench for picomem_dbg_master: directed packets, reset abort and randomized traffic.
// A packet-level reference memory predicts every response byte and bus access.
module tb_picomem_dbg_master;
    logic clk = 1'b0;
    logic resetn;
    logic busy;

    picomem_dbg_master_if bus_if();

`ifdef PICOMEM_DBG_TIMEOUT_EN
    picomem_dbg_master #(.TIMEOUT_CYCLES(16)) dut (.clk(clk), .resetn(resetn), .bus(bus_if), .busy(busy));
`else
    picomem_dbg_master dut (.clk(clk), .resetn(resetn), .bus(bus_if), .busy(busy));
`endif

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    logic [31:0] ref_mem   [256];
    logic [31:0] slave_mem [256];

    int          resp_delay = 0;
    int          vcyc = 0;
    int          last_vcyc = 0;
    int          txn_count = 0;
    logic [31:0] txn_addr, txn_wdata;
    logic [3:0]  txn_wstrb;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Memory responder: ready pulses in valid cycle resp_delay+1; never when resp_delay < 0.
    logic [31:0] a0, w0;
    logic [3:0]  s0;
    initial begin
        bus_if.mem_m_ready = 1'b0;
        bus_if.mem_m_rdata = '0;
        forever begin
            tick();
            bus_if.mem_m_ready = 1'b0;
            bus_if.mem_m_rdata = $urandom;
            if (bus_if.mem_m_valid === 1'b1) begin
                vcyc++;
                last_vcyc = vcyc;
                if (vcyc == 1) begin
                    a0 = bus_if.mem_m_addr;
                    w0 = bus_if.mem_m_wdata;
                    s0 = bus_if.mem_m_wstrb;
                end else begin
                    chk("bus_addr_stable", bus_if.mem_m_addr, a0);
                    chk("bus_wdata_stable", bus_if.mem_m_wdata, w0);
                    chk("bus_wstrb_stable", {28'h0, bus_if.mem_m_wstrb}, {28'h0, s0});
                end
                if (resp_delay >= 0 && vcyc == resp_delay + 1) begin
                    bus_if.mem_m_ready = 1'b1;
                    bus_if.mem_m_rdata = slave_mem[bus_if.mem_m_addr[9:2]];
                    if (bus_if.mem_m_wstrb == 4'hF)
                        slave_mem[bus_if.mem_m_addr[9:2]] = bus_if.mem_m_wdata;
                    txn_addr  = bus_if.mem_m_addr;
                    txn_wdata = bus_if.mem_m_wdata;
                    txn_wstrb = bus_if.mem_m_wstrb;
                    txn_count++;
                end
            end else begin
                vcyc = 0;
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        bit ok = 0;
        bus_if.rx_data  = b;
        bus_if.rx_valid = 1'b1;
        for (int i = 0; i < 200 && !ok; i++) begin
            if (bus_if.rx_ready === 1'b1) ok = 1;
            tick();
        end
        bus_if.rx_valid = 1'b0;
        if (!ok) chk("rx_accept", {31'h0, bus_if.rx_ready}, 32'h1);
    endtask

    task automatic recv_byte(output logic [7:0] b, input int stall);
        logic [7:0] d0;
        b = 8'h00;
        bus_if.tx_ready = 1'b0;
        for (int i = 0; i < 3000 && bus_if.tx_valid !== 1'b1; i++) tick();
        if (bus_if.tx_valid !== 1'b1) begin
            chk("tx_wait", {31'h0, bus_if.tx_valid}, 32'h1);
            return;
        end
        d0 = bus_if.tx_data;
        for (int k = 0; k < stall; k++) begin
            tick();
            chk("tx_stall_data", {24'h0, bus_if.tx_data}, {24'h0, d0});
            chk("tx_stall_valid", {31'h0, bus_if.tx_valid}, 32'h1);
        end
        bus_if.tx_ready = 1'b1;
        b = bus_if.tx_data;
        tick();
        bus_if.tx_ready = 1'b0;
    endtask

    // One full packet: send, predict from the reference memory, collect and compare the reply.
    task automatic run_txn(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] data,
                           input int delay, input int stall_byte, input int stall_len);
        int          start_cnt, nbytes;
        bit          good;
        logic [31:0] exp_word;
        logic [7:0]  b;
        logic [7:0]  idx;
        idx        = addr[9:2];
        resp_delay = delay;
        start_cnt  = txn_count;
        good       = (op == 8'h01 || op == 8'h02) && delay >= 0;
        send_byte(op);
        if (op == 8'h01 || op == 8'h02) begin
            for (int i = 0; i < 4; i++) send_byte(addr[8*i +: 8]);
            if (op == 8'h02)
                for (int i = 0; i < 4; i++) send_byte(data[8*i +: 8]);
            chk("valid_latency", {31'h0, bus_if.mem_m_valid}, 32'h1);
        end
        if (!good) begin
            exp_word = 32'h0000_00EE;
            nbytes   = 1;
        end else if (op == 8'h01) begin
            exp_word = ref_mem[idx];
            nbytes   = 4;
        end else begin
            ref_mem[idx] = data;
            exp_word     = 32'h0000_00AA;
            nbytes       = 1;
        end
        for (int k = 0; k < nbytes; k++) begin
            recv_byte(b, (k == stall_byte) ? stall_len : 0);
            chk($sformatf("tx_byte%0d_op%02h", k, op), {24'h0, b}, {24'h0, exp_word[8*k +: 8]});
        end
        chk("idle_busy", {31'h0, busy}, 32'h0);
        chk("idle_tx_valid", {31'h0, bus_if.tx_valid}, 32'h0);
        chk("txn_count", txn_count - start_cnt, good ? 1 : 0);
        if (good) begin
            chk("txn_addr", txn_addr, {addr[31:2], 2'b00});
            chk("txn_wstrb", {28'h0, txn_wstrb}, (op == 8'h02) ? 32'hF : 32'h0);
            if (op == 8'h02) chk("txn_wdata", txn_wdata, data);
        end
        $display("txn op=%02h addr=%08h data=%08h delay=%0d resp=%08h", op, addr, data, delay, exp_word);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  op;
        logic [31:0] addr, data;
        int          r;

        for (int i = 0; i < 256; i++) begin
            ref_mem[i]   = (32'(i) * 32'h0101_0101) ^ 32'hA5A5_0000;
            slave_mem[i] = (32'(i) * 32'h0101_0101) ^ 32'hA5A5_0000;
        end
        resetn          = 1'b0;
        bus_if.rx_data  = 8'h00;
        bus_if.rx_valid = 1'b0;
        bus_if.tx_ready = 1'b0;
        repeat (3) tick();
        chk("rst_rx_ready", {31'h0, bus_if.rx_ready}, 32'h0);
        chk("rst_tx_valid", {31'h0, bus_if.tx_valid}, 32'h0);
        chk("rst_tx_data", {24'h0, bus_if.tx_data}, 32'h0);
        chk("rst_mem_valid", {31'h0, bus_if.mem_m_valid}, 32'h0);
        chk("rst_mem_addr", bus_if.mem_m_addr, 32'h0);
        chk("rst_mem_wdata", bus_if.mem_m_wdata, 32'h0);
        chk("rst_mem_wstrb", {28'h0, bus_if.mem_m_wstrb}, 32'h0);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        resetn = 1'b1;
        repeat (2) tick();
        chk("post_rst_rx_ready", {31'h0, bus_if.rx_ready}, 32'h1);

        run_txn(8'h02, 32'h4000_0000, 32'h1234_5678, 3, 0, 0);
        ref_mem[1]   = 32'hDEAD_BEEF;
        slave_mem[1] = 32'hDEAD_BEEF;
        run_txn(8'h01, 32'h4000_0004, 32'h0, 0, 0, 0);
        run_txn(8'h7F, 32'h0, 32'h0, 0, 0, 0);
        run_txn(8'h01, 32'h4000_0000, 32'h0, 1, 0, 0);
        run_txn(8'h01, 32'h4000_0013, 32'h0, 2, 2, 10);

        // Reset while the bus access is outstanding aborts it without a reply.
        resp_delay = -1;
        r = txn_count;
        send_byte(8'h01);
        for (int i = 0; i < 4; i++) send_byte(8'h40 >> (8 * (3 - i)));
        repeat (3) tick();
        chk("abort_busy_before", {31'h0, busy}, 32'h1);
        chk("abort_valid_before", {31'h0, bus_if.mem_m_valid}, 32'h1);
        resetn = 1'b0;
        tick();
        chk("abort_valid", {31'h0, bus_if.mem_m_valid}, 32'h0);
        chk("abort_busy", {31'h0, busy}, 32'h0);
        resetn = 1'b1;
        repeat (5) tick();
        chk("abort_no_tx", {31'h0, bus_if.tx_valid}, 32'h0);
        chk("abort_no_txn", txn_count - r, 0);
        run_txn(8'h02, 32'h4000_0020, 32'hCAFE_F00D, 1, 0, 0);
        run_txn(8'h01, 32'h4000_0020, 32'h0, 0, 0, 0);

`ifdef PICOMEM_DBG_TIMEOUT_EN
        run_txn(8'h01, 32'h4000_0008, 32'h0, -1, 0, 0);
        chk("tmo_valid_cycles", last_vcyc, 16);
        run_txn(8'h01, 32'h4000_0008, 32'h0, 15, 0, 0);
        chk("tmo_edge_cycles", last_vcyc, 16);
`endif

        for (int n = 0; n < 25; n++) begin
            r = $urandom_range(0, 9);
            if (r == 0) begin
                op = 8'($urandom);
                if (op == 8'h01 || op == 8'h02) op = 8'h55;
            end else begin
                op = (r < 5) ? 8'h01 : 8'h02;
            end
            addr = 32'h4000_0000 | ($urandom & 32'h0000_03FF);
            data = $urandom;
            run_txn(op, addr, data, $urandom_range(0, 4), $urandom_range(0, 3), $urandom_range(0, 3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
